// File: rtl/sync_fifo_pkg.sv
// Shared helpers and types for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic wr;
    logic rd;
  } fifo_acc_t;

endpackage

// File: rtl/sync_fifo_param_ptr_ctr.sv
// Wrapping pointer counter, modulo DEPTH (not modulo a power of two).
module fifo_ptr_ctr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: arbitrary depth, programmable thresholds,
// optional first-word-fall-through read, synchronous flush and sticky errors.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  overflow_sticky,
  output logic                  underflow_sticky,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (DEPTH < 2) begin : g_chk_depth
    $error("sync_fifo_param: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
    $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_chk_ae
    $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end

  fifo_acc_t             acc;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  ovf_sticky_q, ovf_sticky_d;
  logic                  udf_sticky_q, udf_sticky_d;

  // A read frees a slot in the same cycle, so a full FIFO still takes a write.
  always_comb begin
    acc = '0;
    if (!flush) begin
      acc.rd = rd_en && (count_q != '0);
      acc.wr = wr_en && ((count_q < DEPTH_C) || acc.rd);
    end
  end

  always_comb begin
    count_d = count_q;
    case ({acc.wr, acc.rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) count_d = '0;

    wr_ack_d     = acc.wr;
    overflow_d   = !flush && wr_en && !acc.wr;
    underflow_d  = !flush && rd_en && !acc.rd;
    ovf_sticky_d = flush ? 1'b0 : (ovf_sticky_q | overflow_d);
    udf_sticky_d = flush ? 1'b0 : (udf_sticky_q | underflow_d);

    rd_valid_d = (FWFT == 0) && acc.rd;
    data_out_d = data_out_q;
    if ((FWFT == 0) && acc.rd) data_out_d = mem_q[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      data_out_q   <= '0;
      rd_valid_q   <= 1'b0;
      wr_ack_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      rd_valid_q   <= rd_valid_d;
      wr_ack_q     <= wr_ack_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (acc.wr) mem_q[wr_ptr] <= data_in;
  end

  fifo_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (acc.wr),
    .ptr   (wr_ptr)
  );

  fifo_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (acc.rd),
    .ptr   (rd_ptr)
  );

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= AF_C);
  assign almostempty = (count_q <= AE_C);
  assign count       = count_q;

  assign wr_ack           = wr_ack_q;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;
  assign overflow_sticky  = ovf_sticky_q;
  assign underflow_sticky = udf_sticky_q;

  // FWFT shows zero rather than stale storage while empty.
  assign data_out = (FWFT != 0) ? (empty ? '0 : mem_q[rd_ptr]) : data_out_q;
  assign rd_valid = (FWFT != 0) ? !empty : rd_valid_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a standard-read DEPTH=8 instance and an FWFT DEPTH=6 instance.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_flush, a_wr, a_rd;
  logic [15:0] a_din, a_dout;
  logic        a_vld, a_ack, a_ovf, a_udf, a_ovs, a_uds;
  logic        a_full, a_empty, a_af, a_ae;
  logic [3:0]  a_cnt;

  logic        b_flush, b_wr, b_rd;
  logic [15:0] b_din, b_dout;
  logic        b_vld, b_ack, b_ovf, b_udf, b_ovs, b_uds;
  logic        b_full, b_empty, b_af, b_ae;
  logic [2:0]  b_cnt;

  sync_fifo_param #(
    .DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr), .data_in(a_din),
    .rd_en(a_rd), .data_out(a_dout), .rd_valid(a_vld), .wr_ack(a_ack),
    .overflow(a_ovf), .underflow(a_udf), .overflow_sticky(a_ovs),
    .underflow_sticky(a_uds), .full(a_full), .empty(a_empty),
    .almostfull(a_af), .almostempty(a_ae), .count(a_cnt)
  );

  sync_fifo_param #(
    .DATA_WIDTH(16), .DEPTH(6), .FWFT(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr), .data_in(b_din),
    .rd_en(b_rd), .data_out(b_dout), .rd_valid(b_vld), .wr_ack(b_ack),
    .overflow(b_ovf), .underflow(b_udf), .overflow_sticky(b_ovs),
    .underflow_sticky(b_uds), .full(b_full), .empty(b_empty),
    .almostfull(b_af), .almostempty(b_ae), .count(b_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr, rd, fl;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic [15:0] dout;
    logic        vld, ack, ovf, udf, ovs, uds;
    logic [3:0]  flg;  // {full, empty, almostfull, almostempty}
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic wr, input logic rd, input logic fl,
                            input logic [15:0] din, input logic [3:0] cnt,
                            input logic [15:0] dout, input logic vld, input logic ack,
                            input logic ovf, input logic udf, input logic ovs,
                            input logic uds, input logic [3:0] flg);
    vec_t t;
    t.wr = wr; t.rd = rd; t.fl = fl; t.din = din; t.cnt = cnt; t.dout = dout;
    t.vld = vld; t.ack = ack; t.ovf = ovf; t.udf = udf; t.ovs = ovs; t.uds = uds;
    t.flg = flg;
    vecs.push_back(t);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] model[$];

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_wr = 0; a_rd = 0; a_din = '0;
    b_flush = 0; b_wr = 0; b_rd = 0; b_din = '0;

    //  wr rd fl din       cnt dout      vld ack ovf udf ovs uds flags
    v(1, 0, 0, 16'h0001, 1, 16'h0000, 0, 1, 0, 0, 0, 0, 4'b0001);
    v(1, 0, 0, 16'h0002, 2, 16'h0000, 0, 1, 0, 0, 0, 0, 4'b0001);
    v(1, 0, 0, 16'h0003, 3, 16'h0000, 0, 1, 0, 0, 0, 0, 4'b0000);
    v(1, 0, 0, 16'h0004, 4, 16'h0000, 0, 1, 0, 0, 0, 0, 4'b0000);
    v(1, 0, 0, 16'h0005, 5, 16'h0000, 0, 1, 0, 0, 0, 0, 4'b0000);
    v(1, 0, 0, 16'h0006, 6, 16'h0000, 0, 1, 0, 0, 0, 0, 4'b0010);
    v(1, 0, 0, 16'h0007, 7, 16'h0000, 0, 1, 0, 0, 0, 0, 4'b0010);
    v(1, 0, 0, 16'h0008, 8, 16'h0000, 0, 1, 0, 0, 0, 0, 4'b1010);
    v(1, 1, 0, 16'h0009, 8, 16'h0001, 1, 1, 0, 0, 0, 0, 4'b1010);
    v(1, 0, 0, 16'h000A, 8, 16'h0001, 0, 0, 1, 0, 1, 0, 4'b1010);
    v(0, 0, 0, 16'h0000, 8, 16'h0001, 0, 0, 0, 0, 1, 0, 4'b1010);
    v(0, 1, 0, 16'h0000, 7, 16'h0002, 1, 0, 0, 0, 1, 0, 4'b0010);
    v(0, 1, 0, 16'h0000, 6, 16'h0003, 1, 0, 0, 0, 1, 0, 4'b0010);
    v(0, 1, 0, 16'h0000, 5, 16'h0004, 1, 0, 0, 0, 1, 0, 4'b0000);
    v(0, 1, 0, 16'h0000, 4, 16'h0005, 1, 0, 0, 0, 1, 0, 4'b0000);
    v(0, 1, 0, 16'h0000, 3, 16'h0006, 1, 0, 0, 0, 1, 0, 4'b0000);
    v(0, 1, 0, 16'h0000, 2, 16'h0007, 1, 0, 0, 0, 1, 0, 4'b0001);
    v(0, 1, 0, 16'h0000, 1, 16'h0008, 1, 0, 0, 0, 1, 0, 4'b0001);
    v(0, 1, 0, 16'h0000, 0, 16'h0009, 1, 0, 0, 0, 1, 0, 4'b0101);
    v(0, 1, 0, 16'h0000, 0, 16'h0009, 0, 0, 0, 1, 1, 1, 4'b0101);
    v(1, 1, 0, 16'h0055, 1, 16'h0009, 0, 1, 0, 1, 1, 1, 4'b0001);
    v(0, 1, 0, 16'h0000, 0, 16'h0055, 1, 0, 0, 0, 1, 1, 4'b0101);
    v(1, 0, 0, 16'h0061, 1, 16'h0055, 0, 1, 0, 0, 1, 1, 4'b0001);
    v(1, 0, 0, 16'h0062, 2, 16'h0055, 0, 1, 0, 0, 1, 1, 4'b0001);
    v(1, 0, 0, 16'h0063, 3, 16'h0055, 0, 1, 0, 0, 1, 1, 4'b0000);
    v(1, 0, 0, 16'h0064, 4, 16'h0055, 0, 1, 0, 0, 1, 1, 4'b0000);
    v(1, 0, 1, 16'h0070, 0, 16'h0055, 0, 0, 0, 0, 0, 0, 4'b0101);
    v(1, 0, 0, 16'h0071, 1, 16'h0055, 0, 1, 0, 0, 0, 0, 4'b0001);
    v(0, 1, 0, 16'h0000, 0, 16'h0071, 1, 0, 0, 0, 0, 0, 4'b0101);

    repeat (2) @(posedge clk);
    #1;
    chk("rst a count", a_cnt, 0);
    chk("rst a flags", {a_full, a_empty, a_af, a_ae}, 4'b0101);
    chk("rst a dout", a_dout, 0);
    chk("rst a pulses", {a_vld, a_ack, a_ovf, a_udf, a_ovs, a_uds}, 0);
    chk("rst b flags", {b_full, b_empty, b_vld, b_cnt}, {3'b010, 3'd0});
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      a_wr = vecs[i].wr; a_rd = vecs[i].rd; a_flush = vecs[i].fl; a_din = vecs[i].din;
      step();
      chk($sformatf("v%0d count", i), a_cnt, vecs[i].cnt);
      chk($sformatf("v%0d data_out", i), a_dout, vecs[i].dout);
      chk($sformatf("v%0d rd_valid", i), a_vld, vecs[i].vld);
      chk($sformatf("v%0d wr_ack", i), a_ack, vecs[i].ack);
      chk($sformatf("v%0d overflow", i), a_ovf, vecs[i].ovf);
      chk($sformatf("v%0d underflow", i), a_udf, vecs[i].udf);
      chk($sformatf("v%0d ovf_sticky", i), a_ovs, vecs[i].ovs);
      chk($sformatf("v%0d udf_sticky", i), a_uds, vecs[i].uds);
      chk($sformatf("v%0d flags", i), {a_full, a_empty, a_af, a_ae}, vecs[i].flg);
    end
    a_wr = 0; a_rd = 0; a_flush = 0;

    // Reset asserted between edges in the middle of a write burst.
    a_wr = 1; a_din = 16'h00A1;
    step();
    a_din = 16'h00A2;
    step();
    chk("burst count before reset", a_cnt, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst count", a_cnt, 0);
    chk("async rst flags", {a_full, a_empty, a_af, a_ae}, 4'b0101);
    chk("async rst dout", a_dout, 0);
    chk("async rst pulses", {a_vld, a_ack, a_ovf, a_udf, a_ovs, a_uds}, 0);
    a_wr = 0;
    step();
    rst_n = 1'b1;
    a_wr = 1; a_din = 16'h00BB;
    step();
    a_wr = 0; a_rd = 1;
    step();
    chk("post rst read dout", a_dout, 16'h00BB);
    chk("post rst read count", a_cnt, 0);
    a_rd = 0;

    // FWFT: empty with simultaneous read and write.
    b_wr = 1; b_rd = 1; b_din = 16'hABCD;
    step();
    chk("fwft udf", {b_udf, b_uds, b_ack}, 3'b111);
    chk("fwft count", b_cnt, 1);
    chk("fwft dout", b_dout, 16'hABCD);
    chk("fwft rd_valid", b_vld, 1);
    b_wr = 0;
    step();
    chk("fwft pop empty", {b_empty, b_vld, b_udf, b_uds}, 4'b1001);
    b_rd = 0; b_flush = 1;
    step();
    chk("fwft flush sticky", b_uds, 0);
    b_flush = 0;

    // DEPTH=6 interleaved traffic with wrapping pointers.
    for (int k = 0; k < 5; k++) begin
      b_wr = 1; b_din = 16'h0200 + 16'(k);
      step();
      model.push_back(16'h0200 + 16'(k));
    end
    b_wr = 0;
    for (int i = 0; i < 20; i++) begin
      b_wr = 1; b_din = 16'h0300 + 16'(i);
      step();
      model.push_back(16'h0300 + 16'(i));
      b_wr = 0;
      chk($sformatf("pair%0d count", i), b_cnt, model.size());
      chk($sformatf("pair%0d count<=6", i), {31'b0, b_cnt <= 3'd6}, 1);
      chk($sformatf("pair%0d full", i), b_full, 1);
      chk($sformatf("pair%0d head", i), b_dout, model[0]);
      chk($sformatf("pair%0d valid", i), b_vld, 1);
      b_rd = 1;
      step();
      void'(model.pop_front());
      b_rd = 0;
    end
    for (int g = 0; g < 8 && model.size() > 0; g++) begin
      chk($sformatf("drain%0d head", g), b_dout, model[0]);
      b_rd = 1;
      step();
      void'(model.pop_front());
      b_rd = 0;
    end
    chk("drain empty", {b_empty, b_vld, b_ovs, b_uds}, 4'b1000);
    chk("drain count", b_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO, successor to the team's fixed-function FIFO.
- Adds arbitrary (non-power-of-2) depth, programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) read mode, and an occupancy output.
- Adds a synchronous flush and sticky error flags.
- Sits between producer/consumer blocks in one clock domain.

Parameters:
DATA_WIDTH, 16, width of data_in/data_out
DEPTH, 8, number of entries; any integer >= 2
AF_THRESH, DEPTH-1, almostfull asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almostempty asserts when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents and sticky flags
wr_en  in  1  write request
data_in  in  DATA_WIDTH  write data
rd_en  in  1  read request (pop in FWFT mode)
data_out  out  DATA_WIDTH  read data
rd_valid  out  1  data_out holds valid read data
wr_ack  out  1  registered: previous-cycle write accepted
overflow  out  1  registered: previous-cycle write rejected
underflow  out  1  registered: previous-cycle read rejected
overflow_sticky  out  1  set on any overflow; cleared by flush/reset
underflow_sticky  out  1  set on any underflow; cleared by flush/reset
full  out  1  count == DEPTH
empty  out  1  count == 0
almostfull  out  1  count >= AF_THRESH
almostempty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
Reset (rst_n low, async):
- wr_ptr = rd_ptr = count = 0.
- data_out = 0; rd_valid, wr_ack, overflow, underflow and both sticky flags = 0.
- empty = 1 and almostempty = 1; full = 0 and almostfull = 0.
- Reset asserted mid-burst discards all contents immediately.

Write accept: wr_en && (count < DEPTH || read accepted this cycle).
- Full with simultaneous read: both accepted, count unchanged.

Read accept: rd_en && count != 0.
- Empty with simultaneous write: write accepted, read rejected (underflow), count+1.

count update: +1 on write-only accept, -1 on read-only accept, unchanged on both/neither.

Pointers: wrap from DEPTH-1 to 0. Arithmetic is mod DEPTH, not mod 2^n.

Standard mode (FWFT=0):
- Accepted read loads data_out <= mem[rd_ptr] at the clock edge, so latency is 1.
- rd_valid is high exactly in the cycle after an accepted read.
- data_out holds its value otherwise.

FWFT mode (FWFT=1):
- data_out = mem[rd_ptr] combinationally; rd_valid = !empty.
- rd_en pops the head. A write into an empty FIFO is visible on data_out one cycle after the write edge.

wr_ack, overflow, underflow:
- Each is a one-cycle pulse, registered, in the cycle following the request.
- overflow = wr_en && write rejected; underflow = rd_en && read rejected.

Status flags: full, empty, almostfull, almostempty and count are combinational from the count register.

flush (synchronous, highest priority below reset):
- Pointers, count, stickies, wr_ack, overflow, underflow and rd_valid are set to 0.
- Same-cycle wr_en/rd_en are ignored: no ack, no error.
- data_out is held in standard mode.

Sticky flags: set the cycle overflow/underflow pulses; held until flush or reset.

Illegal parameters (DEPTH<2, thresholds out of range): elaboration-time $error.

Decomposition:
Package sync_fifo_pkg:
- localparam helper function ptr_width(depth) = $clog2(depth), min 1.
- Typedef for the read/write accept-enable struct.

Sub-module fifo_ptr_ctr (parameter DEPTH):
- Wrapping pointer counter with inc, clr (flush) and async rst_n.
- Instantiated twice, for wr_ptr and rd_ptr.

Storage array, count and flag logic live in sync_fifo_param.

Test Plan:
1. DEPTH=8, FWFT=0: write 0x0001..0x0008 on consecutive cycles, then 8 reads -> full=1 after the 8th write edge; data_out 0x0001..0x0008 each one cycle after rd_en with rd_valid=1; empty=1 at end.
2. DEPTH=6 (non-power-of-2): 20 interleaved write/read pairs -> pointers wrap 5->0; data order preserved; count never exceeds 6.
3. Full + wr_en + rd_en, then full + wr_en alone -> first case: wr_ack=1, count stays 8. Second case: overflow=1 for one cycle, overflow_sticky=1 held, count stays 8.
4. Empty + rd_en + wr_en -> underflow=1, underflow_sticky=1, count=1. In FWFT=1, data_out = written word and rd_valid=1 the next cycle.
5. AF_THRESH=6, AE_THRESH=2, DEPTH=8: fill to 5, 6, 7 -> almostfull 0, 1, 1. Drain to 3, 2 -> almostempty 0, 1.
6. 4 entries stored, flush with wr_en=1 -> next cycle count=0, empty=1, stickies=0, no wr_ack. rst_n pulsed low mid-burst -> all outputs at reset values asynchronously.
